pipe_stage_chain: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- A chain of DEPTH register slots carries a control bundle and a datapath bundle between pipeline stages.
- Each slot uses a valid/ready handshake with a 2-entry skid, so a downstream stall never drops a beat and never needs a combinational ready path.
- Flush inserts bubbles with control forced to zero. This replaces per-stage hand-written Rst/Ld registers and adds stall, flush and occupancy tracking.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_slot.sv | 96 +++++++++
 rtl/pipe_stage_chain.sv | 90 +++++++++
 tb/tb_pipe_stage_chain.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register chain.
// Holds the per-boundary bundle widths and the occupancy width helper.
package pipe_pkg;

    // Pipeline boundaries that a chain can sit on
    typedef enum logic [1:0] {
        BOUNDARY_IFID  = 2'd0,
        BOUNDARY_IDEX  = 2'd1,
        BOUNDARY_EXMEM = 2'd2,
        BOUNDARY_MEMWB = 2'd3
    } boundary_e;

    // Default bundle widths per boundary
    localparam int IFID_CTRL_W  = 16;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 16;
    localparam int EXMEM_DATA_W = 128;
    localparam int MEMWB_CTRL_W = 16;
    localparam int MEMWB_DATA_W = 96;

    // Generic defaults used by the chain when no boundary is chosen
    localparam int DEFAULT_CTRL_W = 16;
    localparam int DEFAULT_DATA_W = 128;

    // Largest supported chain length
    localparam int MAX_DEPTH = 8;

    // Width needed to count 0..2*depth beats held in the chain
    function automatic int occWidth(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

    // Control bundle width for a given boundary
    function automatic int ctrlWidth(input boundary_e b);
        case (b)
            BOUNDARY_IFID:  return IFID_CTRL_W;
            BOUNDARY_IDEX:  return IDEX_CTRL_W;
            BOUNDARY_EXMEM: return EXMEM_CTRL_W;
            default:        return MEMWB_CTRL_W;
        endcase
    endfunction

    // Datapath bundle width for a given boundary
    function automatic int dataWidth(input boundary_e b);
        case (b)
            BOUNDARY_IFID:  return IFID_DATA_W;
            BOUNDARY_IDEX:  return IDEX_DATA_W;
            BOUNDARY_EXMEM: return EXMEM_DATA_W;
            default:        return MEMWB_DATA_W;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the chain: a main entry plus a one-deep skid entry.
// Upstream ready comes straight from the skid valid flop, so a downstream
// stall never ripples combinationally back up the chain.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              down_valid_o,
    input  logic              down_ready_i,
    output logic [CTRL_W-1:0] down_ctrl_o,
    output logic [DATA_W-1:0] down_data_o
);

    logic              mainV_q, mainV_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic              skidV_q, skidV_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;

    logic takeMain;
    logic upFire;

    assign takeMain     = mainV_q & down_ready_i;
    assign upFire       = up_valid_i & ~skidV_q;
    assign up_ready_o   = ~skidV_q;
    assign down_valid_o = mainV_q;
    assign down_ctrl_o  = mainCtrl_q;
    assign down_data_o  = mainData_q;

    // Next-state selection: drain skid first, then refill main, else park in skid
    always_comb begin
        mainV_d    = mainV_q;
        mainCtrl_d = mainCtrl_q;
        mainData_d = mainData_q;
        skidV_d    = skidV_q;
        skidCtrl_d = skidCtrl_q;
        skidData_d = skidData_q;
        if (takeMain && skidV_q) begin
            mainV_d    = 1'b1;
            mainCtrl_d = skidCtrl_q;
            mainData_d = skidData_q;
            skidV_d    = 1'b0;
            skidCtrl_d = '0;
        end else if (takeMain && upFire) begin
            mainV_d    = 1'b1;
            mainCtrl_d = up_ctrl_i;
            mainData_d = up_data_i;
        end else if (takeMain) begin
            mainV_d    = 1'b0;
            mainCtrl_d = '0;
        end else if (upFire && !mainV_q) begin
            mainV_d    = 1'b1;
            mainCtrl_d = up_ctrl_i;
            mainData_d = up_data_i;
        end else if (upFire) begin
            skidV_d    = 1'b1;
            skidCtrl_d = up_ctrl_i;
            skidData_d = up_data_i;
        end
    end

    // State registers; flush kills beats and zeroes control but keeps data
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mainV_q    <= 1'b0;
            mainCtrl_q <= '0;
            mainData_q <= '0;
            skidV_q    <= 1'b0;
            skidCtrl_q <= '0;
            skidData_q <= '0;
        end else if (flush) begin
            mainV_q    <= 1'b0;
            mainCtrl_q <= '0;
            skidV_q    <= 1'b0;
            skidCtrl_q <= '0;
        end else begin
            mainV_q    <= mainV_d;
            mainCtrl_q <= mainCtrl_d;
            mainData_q <= mainData_d;
            skidV_q    <= skidV_d;
            skidCtrl_q <= skidCtrl_d;
            skidData_q <= skidData_d;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH skid slots carrying a control and a datapath
// bundle between pipeline stages, with flush and an occupancy counter.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [DATA_W-1:0]           out_data,
    output logic [occWidth(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occWidth(DEPTH);

    // Stage k is the upstream side of slot k; stage DEPTH is the chain output
    logic [DEPTH:0]             stageValid;
    logic [DEPTH:0]             stageReady;
    logic [DEPTH:0][CTRL_W-1:0] stageCtrl;
    logic [DEPTH:0][DATA_W-1:0] stageData;

    logic             inFire;
    logic             outFire;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign stageValid[0]     = in_valid;
    assign stageCtrl[0]      = in_ctrl;
    assign stageData[0]      = in_data;
    assign in_ready          = stageReady[0];
    assign out_valid         = stageValid[DEPTH];
    assign out_ctrl          = stageCtrl[DEPTH];
    assign out_data          = stageData[DEPTH];
    assign stageReady[DEPTH] = out_ready;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : gSlot
            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) uSlot (
                .Clk          (Clk),
                .Rst          (Rst),
                .flush        (flush),
                .up_valid_i   (stageValid[k]),
                .up_ready_o   (stageReady[k]),
                .up_ctrl_i    (stageCtrl[k]),
                .up_data_i    (stageData[k]),
                .down_valid_o (stageValid[k+1]),
                .down_ready_i (stageReady[k+1]),
                .down_ctrl_o  (stageCtrl[k+1]),
                .down_data_o  (stageData[k+1])
            );
        end
    endgenerate

    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign occupancy = occ_q;

    // Occupancy moves by one on a lone accept or a lone consume
    always_comb begin
        occ_d = occ_q;
        if (inFire && !outFire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!inFire && outFire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register, cleared whenever the chain is emptied
    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: four chains of different depth share
// the same inputs, and each scenario checks only the chain it targets.
module tb_pipe_stage_chain;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [15:0]  in_ctrl = '0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;

    logic         d1InReady, d1OutValid;
    logic [15:0]  d1OutCtrl;
    logic [127:0] d1OutData;
    logic [1:0]   d1Occ;
    logic         d2InReady, d2OutValid;
    logic [15:0]  d2OutCtrl;
    logic [127:0] d2OutData;
    logic [2:0]   d2Occ;
    logic         d3InReady, d3OutValid;
    logic [15:0]  d3OutCtrl;
    logic [127:0] d3OutData;
    logic [2:0]   d3Occ;
    logic         d4InReady, d4OutValid;
    logic [15:0]  d4OutCtrl;
    logic [127:0] d4OutData;
    logic [3:0]   d4Occ;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pipe_stage_chain #(.DEPTH(1)) uD1 (
        .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(d1InReady),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d1OutValid), .out_ready(out_ready),
        .out_ctrl(d1OutCtrl), .out_data(d1OutData), .occupancy(d1Occ));
    pipe_stage_chain #(.DEPTH(2)) uD2 (
        .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(d2InReady),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d2OutValid), .out_ready(out_ready),
        .out_ctrl(d2OutCtrl), .out_data(d2OutData), .occupancy(d2Occ));
    pipe_stage_chain #(.DEPTH(3)) uD3 (
        .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(d3InReady),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d3OutValid), .out_ready(out_ready),
        .out_ctrl(d3OutCtrl), .out_data(d3OutData), .occupancy(d3Occ));
    pipe_stage_chain #(.DEPTH(4)) uD4 (
        .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(d4InReady),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d4OutValid), .out_ready(out_ready),
        .out_ctrl(d4OutCtrl), .out_data(d4OutData), .occupancy(d4Occ));

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive the upstream/downstream handshake inputs for the next edge
    task automatic applyStimulus(input logic v, input logic [15:0] c, input logic [127:0] d, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Two-cycle reset with all handshakes idle
    task automatic doReset();
        Rst = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0, 128'h0, 1'b0);
        tick();
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        int peakOcc;
        int accepted;
        int rcvd;
        int sent;
        int seen;
        int bubbleErr;
        int occErr;
        int ctrlErr;
        logic inF;
        logic outF;

        // Reset with a beat offered: nothing may be captured
        Rst = 1'b1;
        applyStimulus(1'b1, 16'hFFFF, {4{32'hDEADBEEF}}, 1'b1);
        tick();
        tick();
        Rst = 1'b0;
        checkOutput("rst_out_valid", 128'(d1OutValid), 128'd0);
        checkOutput("rst_out_ctrl", 128'(d1OutCtrl), 128'd0);
        checkOutput("rst_out_data", d1OutData, 128'd0);
        checkOutput("rst_occupancy", 128'(d1Occ), 128'd0);
        checkOutput("rst_in_ready", 128'(d1InReady), 128'd1);

        // Streaming through DEPTH=3 with no stalls
        doReset();
        peakOcc = 0;
        for (int s = 0; s < 14; s++) begin
            applyStimulus(s < 10, 16'(s + 1), 128'(s + 1), 1'b1);
            tick();
            if ((s >= 2) && (s <= 11)) begin
                checkOutput("stream_valid", 128'(d3OutValid), 128'd1);
                checkOutput("stream_ctrl", 128'(d3OutCtrl), 128'(s - 1));
            end else begin
                checkOutput("stream_valid", 128'(d3OutValid), 128'd0);
                checkOutput("stream_ctrl", 128'(d3OutCtrl), 128'd0);
            end
            if (int'(d3Occ) > peakOcc) peakOcc = int'(d3Occ);
        end
        checkOutput("stream_peak_occ", 128'(peakOcc), 128'd3);

        // Stall with DEPTH=2: four beats fill both slots and both skids
        doReset();
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 16'hA1 + 16'(accepted), 128'(accepted), 1'b0);
            inF = d2InReady;
            tick();
            if (inF) accepted++;
        end
        checkOutput("stall_accepted", 128'(accepted), 128'd4);
        checkOutput("stall_in_ready", 128'(d2InReady), 128'd0);
        checkOutput("stall_occupancy", 128'(d2Occ), 128'd4);
        checkOutput("stall_head_ctrl", 128'(d2OutCtrl), 128'hA1);
        rcvd = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(accepted < 6, 16'hA1 + 16'(accepted), 128'(accepted), 1'b1);
            inF  = in_valid && d2InReady;
            outF = d2OutValid && out_ready;
            if (outF) begin
                checkOutput("stall_order", 128'(d2OutCtrl), 128'(16'hA1 + 16'(rcvd)));
                rcvd++;
            end
            tick();
            if (inF) accepted++;
        end
        checkOutput("stall_received", 128'(rcvd), 128'd6);
        checkOutput("stall_drained_occ", 128'(d2Occ), 128'd0);

        // Flush DEPTH=2 holding three beats while a new beat is offered
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 16'(c + 1), 128'(c + 1), 1'b0);
            tick();
        end
        checkOutput("flush_pre_occ", 128'(d2Occ), 128'd3);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h0055, 128'h55, 1'b0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0, 128'h0, 1'b1);
        checkOutput("flush_out_valid", 128'(d2OutValid), 128'd0);
        checkOutput("flush_out_ctrl", 128'(d2OutCtrl), 128'd0);
        checkOutput("flush_occupancy", 128'(d2Occ), 128'd0);
        checkOutput("flush_in_ready", 128'(d2InReady), 128'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (d2OutValid) seen++;
        end
        checkOutput("flush_no_beats", 128'(seen), 128'd0);

        // Random stalls on DEPTH=4 with a counting scoreboard
        doReset();
        sent = 0;
        rcvd = 0;
        bubbleErr = 0;
        occErr = 0;
        ctrlErr = 0;
        for (int cyc = 0; (cyc < 5000) && (rcvd < 1000); cyc++) begin
            applyStimulus(sent < 1000, 16'(sent + 1), 128'(sent), 1'($urandom_range(0, 1)));
            inF  = in_valid && d4InReady;
            outF = d4OutValid && out_ready;
            if (int'(d4Occ) != (sent - rcvd)) occErr++;
            if (!d4OutValid && (d4OutCtrl != 16'h0)) bubbleErr++;
            if (outF) begin
                checkOutput("rand_data", d4OutData, 128'(rcvd));
                if (d4OutCtrl != 16'(rcvd + 1)) ctrlErr++;
                rcvd++;
            end
            tick();
            if (inF) sent++;
        end
        checkOutput("rand_received", 128'(rcvd), 128'd1000);
        checkOutput("rand_ctrl_errs", 128'(ctrlErr), 128'd0);
        checkOutput("rand_bubble_ctrl", 128'(bubbleErr), 128'd0);
        checkOutput("rand_occ_errs", 128'(occErr), 128'd0);

        // Simultaneous accept and consume on DEPTH=1
        doReset();
        applyStimulus(1'b1, 16'h0011, 128'h11, 1'b0);
        tick();
        checkOutput("simul_pre_occ", 128'(d1Occ), 128'd1);
        checkOutput("simul_pre_ready", 128'(d1InReady), 128'd1);
        applyStimulus(1'b1, 16'h0022, 128'h22, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 128'h0, 1'b0);
        checkOutput("simul_out_valid", 128'(d1OutValid), 128'd1);
        checkOutput("simul_out_ctrl", 128'(d1OutCtrl), 128'h22);
        checkOutput("simul_out_data", d1OutData, 128'h22);
        checkOutput("simul_occupancy", 128'(d1Occ), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
